lock_arbiter: RTL and testbench

Arbitrates exclusive ownership of the shared lock among `N_CLIENTS` requesters and drives the lock register's `lock_req`/`unlock` inputs, sitting directly upstream of it. The lock register's `locked` output is consumed back as the acquire/release acknowledgement. The block adds round-robin fairness, per-client one-hot grants and a hold-timeout watchdog that forces release of a stuck owner.

---
 rtl/lock_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/lock_arbiter.sv | 129 ++++++++++++
 tb/tb_lock_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and default parameters for the lock arbiter.
package lock_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAcquire,
      StHeld,
      StRelease
   } lock_state_e;

   localparam int unsigned DefNClients = 4;
   localparam int unsigned DefTimeout  = 255;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_owner+1 with wraparound.
module rr_arbiter #(
   parameter int unsigned NClients = 4,
   parameter int unsigned IdW      = 2
) (
   input  logic [NClients-1:0] req_i,
   input  logic [IdW-1:0]      last_owner_i,
   output logic [IdW-1:0]      winner_o,
   output logic                found_o
);

   logic [IdW-1:0] idx;

   // First requester after the previous owner wins; the previous owner is checked last.
   always_comb begin
      winner_o = '0;
      found_o  = 1'b0;
      idx      = '0;
      for (int unsigned i = 1; i <= NClients; i++) begin
         idx = IdW'((32'(last_owner_i) + i) % NClients);
         if (!found_o && req_i[idx]) begin
            found_o  = 1'b1;
            winner_o = idx;
         end
      end
   end

endmodule

// File: rtl/lock_arbiter.sv
// Round-robin arbiter in front of the shared lock register, with a hold-timeout watchdog.
module lock_arbiter
   import lock_pkg::*;
#(
   parameter int unsigned NClients = DefNClients,
   parameter int unsigned Timeout  = DefTimeout,
   parameter int unsigned IdW      = $clog2(NClients)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NClients-1:0] req_i,
   input  logic [NClients-1:0] rel_i,
   input  logic                locked_i,
   output logic                lock_req_o,
   output logic                unlock_o,
   output logic [NClients-1:0] grant_o,
   output logic [IdW-1:0]      owner_o,
   output logic                busy_o,
   output logic                timeout_evt_o
);

   localparam int unsigned      CntW    = $clog2(Timeout + 1);
   localparam logic [CntW-1:0]  CntLast = CntW'(Timeout - 1);
   localparam logic [CntW-1:0]  CntMax  = {CntW{1'b1}};

   lock_state_e         state_q, state_d;
   logic [IdW-1:0]      owner_q, owner_d;
   logic [IdW-1:0]      last_owner_q, last_owner_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                lock_req_q, lock_req_d;
   logic                unlock_q, unlock_d;
   logic [NClients-1:0] grant_q, grant_d;
   logic                busy_q, busy_d;
   logic                tmo_q, tmo_d;

   logic [IdW-1:0]      winner;
   logic                found;

   rr_arbiter #(
      .NClients (NClients),
      .IdW      (IdW)
   ) u_rr_arbiter (
      .req_i        (req_i),
      .last_owner_i (last_owner_q),
      .winner_o     (winner),
      .found_o      (found)
   );

   // Next state, owner bookkeeping, hold counter and next registered outputs.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      tmo_d        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               owner_d = winner;
               state_d = StAcquire;
            end
         end
         StAcquire: begin
            if (locked_i) begin
               state_d = StHeld;
               cnt_d   = '0;
            end
         end
         StHeld: begin
            // Explicit release or abandon beats the watchdog.
            if (rel_i[owner_q] || !req_i[owner_q]) begin
               state_d = StRelease;
            end else if (cnt_q == CntLast) begin
               state_d = StRelease;
               tmo_d   = 1'b1;
            end else if (cnt_q != CntMax) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRelease: begin
            if (!locked_i) begin
               state_d      = StIdle;
               last_owner_d = owner_q;
            end
         end
         default: state_d = StIdle;
      endcase

      // lock_req only from the second ACQUIRE cycle on, and dropped once locked is seen.
      lock_req_d = (state_q == StAcquire) && (state_d == StAcquire);
      unlock_d   = (state_d == StRelease);
      grant_d    = (state_d == StHeld) ? (NClients'(1) << owner_d) : '0;
      busy_d     = (state_d != StIdle);
   end

   // State and registered outputs; reset is synchronous.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         owner_q      <= '0;
         last_owner_q <= IdW'(NClients - 1);
         cnt_q        <= '0;
         lock_req_q   <= 1'b0;
         unlock_q     <= 1'b0;
         grant_q      <= '0;
         busy_q       <= 1'b0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
         lock_req_q   <= lock_req_d;
         unlock_q     <= unlock_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         tmo_q        <= tmo_d;
      end
   end

   assign lock_req_o    = lock_req_q;
   assign unlock_o      = unlock_q;
   assign grant_o       = grant_q;
   assign owner_o       = owner_q;
   assign busy_o        = busy_q;
   assign timeout_evt_o = tmo_q;

endmodule

// File: tb/tb_lock_arbiter.sv
// Directed bench for lock_arbiter with a behavioural lock register in the loop.
module tb_lock_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned TMO = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] req;
   logic [N-1:0] rel;
   logic         locked;
   logic         lock_req;
   logic         unlock;
   logic [N-1:0] grant;
   logic [1:0]   owner;
   logic         busy;
   logic         timeout_evt;

   int vectors    = 0;
   int miscompares = 0;
   int overlap    = 0;

   always #5 clk = ~clk;

   lock_arbiter #(
      .NClients (N),
      .Timeout  (TMO)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_i         (req),
      .rel_i         (rel),
      .locked_i      (locked),
      .lock_req_o    (lock_req),
      .unlock_o      (unlock),
      .grant_o       (grant),
      .owner_o       (owner),
      .busy_o        (busy),
      .timeout_evt_o (timeout_evt)
   );

   // Lock register model: set by lock_req, cleared by unlock, shares the reset.
   always @(posedge clk) begin
      if (!rst_n)        locked <= 1'b0;
      else if (lock_req) locked <= 1'b1;
      else if (unlock)   locked <= 1'b0;
   end

   always @(negedge clk) begin
      if (lock_req && unlock) overlap++;
   end

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (grant != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '0; rel = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({lock_req, unlock, grant, busy, timeout_evt, owner} !== 10'b0) begin
         miscompares++;
         $display("FAIL reset_state: got lr=%b ul=%b gr=%b busy=%b tmo=%b own=%0d, want all 0",
                  lock_req, unlock, grant, busy, timeout_evt, owner);
      end
   endtask

   task automatic test_single();
      bit ok;
      req = 4'b0010;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || owner !== 2'd1 || lock_req !== 1'b0) begin
         miscompares++;
         $display("FAIL single_decide: busy=%b owner=%0d lr=%b, want 1 1 0", busy, owner, lock_req);
      end
      @(negedge clk);
      vectors++;
      if (lock_req !== 1'b1) begin
         miscompares++;
         $display("FAIL single_lock_req_cycle2: got %b want 1", lock_req);
      end
      @(negedge clk);
      vectors++;
      if (grant !== 4'b0000 || lock_req !== 1'b1) begin
         miscompares++;
         $display("FAIL single_pre_grant: grant=%b lr=%b want 0000 1", grant, lock_req);
      end
      @(negedge clk);
      vectors++;
      if (grant !== 4'b0010 || owner !== 2'd1 || lock_req !== 1'b0) begin
         miscompares++;
         $display("FAIL single_grant: grant=%b owner=%0d lr=%b want 0010 1 0", grant, owner, lock_req);
      end
      rel = 4'b0010;
      @(negedge clk);
      vectors++;
      if (grant !== 4'b0000 || unlock !== 1'b1) begin
         miscompares++;
         $display("FAIL single_release: grant=%b unlock=%b want 0000 1", grant, unlock);
      end
      rel = '0; req = '0;
      wait_idle(ok);
      vectors++;
      if (!ok || unlock !== 1'b0) begin
         miscompares++;
         $display("FAIL single_idle: reached=%b unlock=%b want 1 0", ok, unlock);
      end
   endtask

   task automatic test_abandon();
      bit ok;
      req = 4'b1000;
      repeat (2) @(negedge clk);
      req = '0;
      wait_grant(ok);
      vectors++;
      if (!ok || grant !== 4'b1000) begin
         miscompares++;
         $display("FAIL abandon_grant: grant=%b want 1000", grant);
      end
      @(negedge clk);
      vectors++;
      if (grant !== 4'b0000 || unlock !== 1'b1) begin
         miscompares++;
         $display("FAIL abandon_one_cycle: grant=%b unlock=%b want 0000 1", grant, unlock);
      end
      wait_idle(ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL abandon_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_rotation();
      bit ok;
      logic [N-1:0] exp;
      req = 4'hF;
      for (int t = 0; t < 5; t++) begin
         exp = 4'b0001 << (t % 4);
         wait_grant(ok);
         vectors++;
         if (!ok || grant !== exp) begin
            miscompares++;
            $display("FAIL rotation_%0d: grant=%b want %b", t, grant, exp);
         end
         repeat (2) @(negedge clk);
         rel = exp;
         @(negedge clk);
         rel = '0;
         if (t == 4) req = '0;
      end
      wait_idle(ok);
      vectors++;
      if (!ok || overlap != 0) begin
         miscompares++;
         $display("FAIL rotation_no_overlap: idle=%b overlaps=%0d want 1 0", ok, overlap);
      end
   endtask

   task automatic test_timeout();
      bit ok;
      int k;
      req = 4'b0001;
      wait_grant(ok);
      k = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         k++;
         if (timeout_evt) break;
      end
      vectors++;
      if (!ok || k != 8 || grant !== 4'b0000 || unlock !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_fire: cycles=%0d grant=%b unlock=%b want 8 0000 1", k, grant, unlock);
      end
      req = '0;
      @(negedge clk);
      vectors++;
      if (timeout_evt !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_pulse: tmo=%b want 0", timeout_evt);
      end
      wait_idle(ok);
   endtask

   task automatic test_nonowner();
      bit ok;
      req = 4'b0001;
      wait_grant(ok);
      rel = 4'b0100;
      @(negedge clk);
      rel = '0;
      vectors++;
      if (!ok || grant !== 4'b0001 || unlock !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL nonowner_rel: grant=%b unlock=%b busy=%b want 0001 0 1", grant, unlock, busy);
      end
      repeat (6) @(negedge clk);
      vectors++;
      if (grant !== 4'b0001 || timeout_evt !== 1'b0) begin
         miscompares++;
         $display("FAIL nonowner_still_held: grant=%b tmo=%b want 0001 0", grant, timeout_evt);
      end
      rel = 4'b0001;
      @(negedge clk);
      vectors++;
      if (grant !== 4'b0000 || unlock !== 1'b1 || timeout_evt !== 1'b0) begin
         miscompares++;
         $display("FAIL rel_beats_timeout: grant=%b unlock=%b tmo=%b want 0000 1 0",
                  grant, unlock, timeout_evt);
      end
      rel = '0; req = '0;
      wait_idle(ok);
   endtask

   task automatic test_reset_mid();
      bit ok;
      req = 4'b0010;
      wait_grant(ok);
      vectors++;
      if (!ok || grant !== 4'b0010) begin
         miscompares++;
         $display("FAIL reset_mid_pre: grant=%b want 0010", grant);
      end
      rst_n = 1'b0;
      @(negedge clk);
      vectors++;
      if ({grant, lock_req, unlock, busy, timeout_evt, owner} !== 10'b0) begin
         miscompares++;
         $display("FAIL reset_mid: gr=%b lr=%b ul=%b busy=%b tmo=%b own=%0d want all 0",
                  grant, lock_req, unlock, busy, timeout_evt, owner);
      end
      rst_n = 1'b1; req = 4'hF;
      wait_grant(ok);
      vectors++;
      if (!ok || grant !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset_first_winner: grant=%b want 0001", grant);
      end
      rel = 4'b0001; req = '0;
      @(negedge clk);
      rel = '0;
      wait_idle(ok);
   endtask

   initial begin
      rst_n = 1'b0; req = '0; rel = '0;
      test_reset();
      test_single();
      test_abandon();
      test_rotation();
      test_timeout();
      test_nonowner();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
